// File: rtl/an13_pkg.sv
// Shared constants, types and the Barrett divide-by-13 helper for the AN13 decoder.
package an13_pkg;

  localparam int A         = 13;
  localparam int BARRETT_M = 19;
  localparam int BARRETT_K = 8;
  localparam int MSG_W     = 3;
  localparam int RES_W     = 4;
  localparam int Q_W       = 4;
  localparam int CW_BITS   = 7;

  typedef enum logic {
    SRC_REQ0 = 1'b0,
    SRC_REQ1 = 1'b1
  } src_e;

  typedef struct packed {
    logic [Q_W-1:0]   q;
    logic [RES_W-1:0] r;
  } divmod_t;

  // The 19/256 estimate never overshoots cw/13 and undershoots by at most one.
  function automatic divmod_t an13_divmod(input logic [CW_BITS-1:0] cw);
    logic [CW_BITS+4:0] prod;
    logic [Q_W-1:0]     q_est;
    logic [CW_BITS:0]   r_raw;
    divmod_t            res;
    prod  = {5'd0, cw} * 12'(BARRETT_M);
    q_est = 4'(prod >> BARRETT_K);
    r_raw = {1'b0, cw} - (8'(A) * {4'd0, q_est});
    if (r_raw >= 8'(A)) begin
      res.q = q_est + 4'd1;
      res.r = 4'(r_raw - 8'(A));
    end else begin
      res.q = q_est;
      res.r = r_raw[RES_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/an13_corr_lut.sv
// Residue-to-quotient-offset table for AN13 single-error correction.
module an13_corr_lut
  import an13_pkg::*;
(
  input  logic [RES_W-1:0]  residue,
  output logic signed [2:0] offset
);

  // Combinational residue lookup; unused residues 13-15 give no correction.
  always_comb begin
    offset = 3'sb000;
    case (residue)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd8: offset = 3'sb000;
      4'd3:                         offset = 3'sb111;
      4'd6:                         offset = 3'sb110;
      4'd5, 4'd9, 4'd11, 4'd12:     offset = 3'sb001;
      4'd10:                        offset = 3'sb010;
      4'd7:                         offset = 3'sb011;
      default:                      offset = 3'sb000;
    endcase
  end

endmodule

// File: rtl/an13_decode_ctrl.sv
// Two-requester round-robin AN13 decoder with a 3-stage stallable pipeline.
// Optional per-source error counters are enabled by defining AN13_ERR_CNT_EN.
module an13_decode_ctrl
  import an13_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int CW_W  = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [CW_W-1:0] req0_cw,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [CW_W-1:0] req1_cw,
  output logic            req1_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_msg,
  output logic            out_err,
  output logic            out_ovf,
  output logic            out_src
`ifdef AN13_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt0,
  output logic [CNT_W-1:0] err_cnt1
`endif
);

  logic            en1_s, en2_s, en3_s;
  logic            gnt0_s, gnt1_s;
  src_e            last_r;

  logic            s1_valid_r;
  logic [CW_W-1:0] s1_cw_r;
  logic            s1_src_r;

  logic            s2_valid_r;
  logic [Q_W-1:0]  s2_q_r;
  logic [RES_W-1:0] s2_r_r;
  logic            s2_src_r;

  divmod_t          dm_s;
  logic signed [2:0] offset_s;
  logic signed [5:0] sum_s;
  logic [MSG_W-1:0] msg_s;
  logic            ovf_s;
  logic            err_s;

  // Stage enables: a stage moves when it is empty or the stage after it moves.
  always_comb begin
    en3_s = !out_valid || out_ready;
    en2_s = !s2_valid_r || en3_s;
    en1_s = !s1_valid_r || en2_s;
  end

  // Round-robin grant; contention goes to the requester not served last.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst_n && en1_s) begin
      case ({req1_valid, req0_valid})
        2'b01:   gnt0_s = 1'b1;
        2'b10:   gnt1_s = 1'b1;
        2'b11: begin
          if (last_r == SRC_REQ0) begin
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = 1'b1;
          end
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;

  // Stage 1: capture the granted codeword and update the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_cw_r    <= {CW_W{1'b0}};
      s1_src_r   <= 1'b0;
      last_r     <= SRC_REQ1;
    end else if (en1_s) begin
      s1_valid_r <= gnt0_s || gnt1_s;
      if (gnt1_s) begin
        s1_cw_r  <= req1_cw;
        s1_src_r <= 1'b1;
        last_r   <= SRC_REQ1;
      end else if (gnt0_s) begin
        s1_cw_r  <= req0_cw;
        s1_src_r <= 1'b0;
        last_r   <= SRC_REQ0;
      end
    end
  end

  // Barrett quotient/residue of the stage-1 codeword.
  always_comb begin
    dm_s = an13_divmod(s1_cw_r);
  end

  // Stage 2: register quotient and residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_q_r     <= {Q_W{1'b0}};
      s2_r_r     <= {RES_W{1'b0}};
      s2_src_r   <= 1'b0;
    end else if (en2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_q_r   <= dm_s.q;
        s2_r_r   <= dm_s.r;
        s2_src_r <= s1_src_r;
      end
    end
  end

  an13_corr_lut u_corr_lut (
    .residue (s2_r_r),
    .offset  (offset_s)
  );

  // Correction: the message wraps in 3 bits, overflow flags any escape from 0..7.
  always_comb begin
    sum_s = $signed({2'b00, s2_q_r}) + $signed({{3{offset_s[2]}}, offset_s});
    msg_s = sum_s[MSG_W-1:0];
    ovf_s = (s2_q_r > 4'd7) || (sum_s < 6'sd0) || (sum_s > 6'sd7);
    err_s = (s2_r_r != 4'd0);
  end

  // Stage 3: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_msg   <= 3'd0;
      out_err   <= 1'b0;
      out_ovf   <= 1'b0;
      out_src   <= 1'b0;
    end else if (en3_s) begin
      out_valid <= s2_valid_r;
      if (s2_valid_r) begin
        out_msg <= msg_s;
        out_err <= err_s;
        out_ovf <= ovf_s;
        out_src <= s2_src_r;
      end
    end
  end

`ifdef AN13_ERR_CNT_EN
  logic out_fire_s;

  assign out_fire_s = out_valid && out_ready && out_err;

  // Saturating error counter for requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt0 <= {CNT_W{1'b0}};
    end else if (out_fire_s && (out_src == SRC_REQ0) && (err_cnt0 != {CNT_W{1'b1}})) begin
      err_cnt0 <= err_cnt0 + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Saturating error counter for requester 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt1 <= {CNT_W{1'b0}};
    end else if (out_fire_s && (out_src == SRC_REQ1) && (err_cnt1 != {CNT_W{1'b1}})) begin
      err_cnt1 <= err_cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_an13_decode_ctrl.sv
// Directed self-checking bench for an13_decode_ctrl.
module tb_an13_decode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [6:0] req0_cw, req1_cw;
  logic       req0_ready, req1_ready;
  logic       out_valid, out_ready;
  logic [2:0] out_msg;
  logic       out_err, out_ovf, out_src;
`ifdef AN13_ERR_CNT_EN
  logic [7:0] err_cnt0, err_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  an13_decode_ctrl #(.CNT_W(8), .CW_W(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_cw    (req0_cw),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_cw    (req1_cw),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_msg    (out_msg),
    .out_err    (out_err),
    .out_ovf    (out_ovf),
    .out_src    (out_src)
`ifdef AN13_ERR_CNT_EN
    ,
    .err_cnt0   (err_cnt0),
    .err_cnt1   (err_cnt1)
`endif
  );

  // Single-transaction vectors: src, codeword, expected msg/err/ovf (hand-computed).
  logic       dec_src [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [6:0] dec_cw  [12] = '{7'd65, 7'd73, 7'd68, 7'd46, 7'd0, 7'd91, 7'd127, 7'd3, 7'd6, 7'd98, 7'd12, 7'd125};
  logic [2:0] dec_msg [12] = '{3'd5, 3'd5, 3'd4, 3'd6, 3'd0, 3'd7, 3'd3, 3'd7, 3'd6, 3'd2, 3'd1, 3'd1};
  logic       dec_err [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       dec_ovf [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  logic [6:0] bp_cw  [5] = '{7'd13, 7'd27, 7'd39, 7'd53, 7'd65};
  logic [2:0] bp_msg [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic       bp_err [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       bp_rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_cw = 7'd65;
    req1_cw = 7'd73;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_msg !== 3'd0 || out_err !== 1'b0 || out_ovf !== 1'b0 || out_src !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b msg=%0d err=%b ovf=%b src=%b expected all zero", out_valid, out_msg, out_err, out_ovf, out_src);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got r0=%b r1=%b expected 0 0", req0_ready, req1_ready);
    end
`ifdef AN13_ERR_CNT_EN
    checks++;
    if (err_cnt0 !== 8'd0 || err_cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d %0d expected 0 0", err_cnt0, err_cnt1);
    end
`endif
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    for (int i = 0; i < 12; i++) begin
      if (dec_src[i]) begin
        req1_valid = 1'b1;
        req1_cw = dec_cw[i];
      end else begin
        req0_valid = 1'b1;
        req0_cw = dec_cw[i];
      end
      #1;
      checks++;
      if ((dec_src[i] ? req1_ready : req0_ready) !== 1'b1) begin
        errors++;
        $display("FAIL decode_grant[%0d]: got r0=%b r1=%b expected grant to req%0d", i, req0_ready, req1_ready, dec_src[i]);
      end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL decode_early[%0d]: got out_valid=%b expected 0", i, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_msg !== dec_msg[i] || out_err !== dec_err[i] || out_ovf !== dec_ovf[i] || out_src !== dec_src[i]) begin
        errors++;
        $display("FAIL decode[%0d] cw=%0d: got v=%b msg=%0d err=%b ovf=%b src=%b expected v=1 msg=%0d err=%b ovf=%b src=%b",
                 i, dec_cw[i], out_valid, out_msg, out_err, out_ovf, out_src, dec_msg[i], dec_err[i], dec_ovf[i], dec_src[i]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL decode_drop[%0d]: got out_valid=%b expected 0", i, out_valid);
      end
    end
`ifdef AN13_ERR_CNT_EN
    checks++;
    if (err_cnt0 !== 8'd7 || err_cnt1 !== 8'd2) begin
      errors++;
      $display("FAIL err_cnt: got %0d %0d expected 7 2", err_cnt0, err_cnt1);
    end
`endif
  endtask

  task automatic test_round_robin();
    logic exp0;
    logic exp_src;
    pulse_reset();
    req0_cw = 7'd13;
    req1_cw = 7'd26;
    for (int c = 0; c < 12; c++) begin
      req0_valid = (c < 6);
      req1_valid = (c < 6);
      #1;
      if (c < 6) begin
        exp0 = ((c % 2) == 0);
        checks++;
        if (req0_ready !== exp0 || req1_ready !== !exp0) begin
          errors++;
          $display("FAIL rr_grant[%0d]: got r0=%b r1=%b expected r0=%b r1=%b", c, req0_ready, req1_ready, exp0, !exp0);
        end
      end
      checks++;
      if (out_valid !== (c >= 3 && c <= 8)) begin
        errors++;
        $display("FAIL rr_valid[%0d]: got %b expected %b", c, out_valid, (c >= 3 && c <= 8));
      end else if (out_valid) begin
        exp_src = (((c - 3) % 2) == 1);
        checks++;
        if (out_src !== exp_src || out_msg !== (exp_src ? 3'd2 : 3'd1)) begin
          errors++;
          $display("FAIL rr_seq[%0d]: got src=%b msg=%0d expected src=%b msg=%0d", c, out_src, out_msg, exp_src, (exp_src ? 2 : 1));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int   idx;
    int   oidx;
    logic stalled_prev;
    logic [2:0] held_msg;
    logic held_err;
    idx = 0;
    oidx = 0;
    stalled_prev = 1'b0;
    held_msg = 3'd0;
    held_err = 1'b0;
    pulse_reset();
    for (int c = 0; c < 16; c++) begin
      out_ready = !(c >= 2 && c <= 5);
      req0_valid = (idx < 5);
      req0_cw = (idx < 5) ? bp_cw[idx] : 7'd0;
      #1;
      if (c < 8) begin
        checks++;
        if (req0_ready !== bp_rdy[c]) begin
          errors++;
          $display("FAIL bp_ready[%0d]: got %b expected %b", c, req0_ready, bp_rdy[c]);
        end
      end
      if (out_valid && stalled_prev) begin
        checks++;
        if (out_msg !== held_msg || out_err !== held_err) begin
          errors++;
          $display("FAIL bp_hold[%0d]: got msg=%0d err=%b expected msg=%0d err=%b", c, out_msg, out_err, held_msg, held_err);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (oidx >= 5) begin
          errors++;
          $display("FAIL bp_extra[%0d]: got result msg=%0d expected none", c, out_msg);
        end else if (out_msg !== bp_msg[oidx] || out_err !== bp_err[oidx] || out_src !== 1'b0) begin
          errors++;
          $display("FAIL bp_order[%0d]: got msg=%0d err=%b src=%b expected msg=%0d err=%b src=0", oidx, out_msg, out_err, out_src, bp_msg[oidx], bp_err[oidx]);
        end
        oidx++;
      end
      stalled_prev = out_valid && !out_ready;
      held_msg = out_msg;
      held_err = out_err;
      if (req0_ready) idx++;
      tick();
    end
    out_ready = 1'b1;
    req0_valid = 1'b0;
    checks++;
    if (oidx != 5 || idx != 5) begin
      errors++;
      $display("FAIL bp_count: got %0d results %0d accepted expected 5 5", oidx, idx);
    end
  endtask

  task automatic test_reset_midflight();
    pulse_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req0_valid = 1'b1;
      req0_cw = 7'd13 * 7'(c + 1);
      tick();
    end
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_msg !== 3'd0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: got v=%b msg=%0d r0=%b r1=%b expected 0 0 0 0", out_valid, out_msg, req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale[%0d]: got out_valid=%b expected 0", c, out_valid);
      end
      tick();
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_cw = 7'd78;
    req1_cw = 7'd26;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_favour: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_early: got out_valid=%b expected 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_msg !== 3'd6 || out_src !== 1'b0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_first: got v=%b msg=%0d src=%b err=%b expected 1 6 0 0", out_valid, out_msg, out_src, out_err);
    end
`ifdef AN13_ERR_CNT_EN
    checks++;
    if (err_cnt0 !== 8'd0) begin
      errors++;
      $display("FAIL midrst_cnt: got %0d expected 0", err_cnt0);
    end
`endif
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_cw = 7'd0;
    req1_cw = 7'd0;
    out_ready = 1'b1;
    #1;
    test_reset();
    test_decode();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/an13_decode_ctrl.md
AN13_DECODE_CTRL -- requirements
Module: an13_decode_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of each error counter.
REQ-002 SHALL have parameter CW_W, default 7, giving the codeword width; only 7 is supported.
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 each; requester offers a codeword.
REQ-006 SHALL have ports req0_cw/req1_cw, input, CW_W each; AN codeword with A=13.
REQ-007 SHALL have ports req0_ready/req1_ready, output, 1 each; codeword accepted this cycle.
REQ-008 SHALL have port out_valid, output, 1; result valid.
REQ-009 SHALL have port out_ready, input, 1; consumer accepts the result.
REQ-010 SHALL have port out_msg, output, 3; corrected message.
REQ-011 SHALL have port out_err, output, 1; residue was nonzero and a correction was applied.
REQ-012 SHALL have port out_ovf, output, 1; quotient exceeded 7 or the corrected message wrapped.
REQ-013 SHALL have port out_src, output, 1; index of the requester the result belongs to.

Function
REQ-014 SHALL arbitrate round-robin: when both requesters are valid, grant the one that was not granted last; a single valid requester is granted directly.
REQ-015 SHALL assert at most one reqN_ready per cycle, and only when stage 1 is empty or advancing.
REQ-016 SHALL run a 3-stage pipeline.
  - S1: register cw and src.
  - S2: Barrett estimate q=(cw*19)>>8 and r=cw-13*q; if r>=13 then r-=13 and q+=1 (at most one step); q is 4 bits.
  - S3: LUT correction, then the output register.
REQ-017 SHALL apply this correction: r in {0,1,2,4,8} gives q; 3 gives q-1; 6 gives q-2; {5,9,11,12} give q+1; 10 gives q+2; 7 gives q+3.
REQ-018 SHALL perform the correction in 3-bit wrap-around arithmetic; out_ovf=1 if q>7 or the unwrapped result is outside 0..7.
REQ-019 SHALL set out_err=1 exactly when r!=0.
REQ-020 SHALL have a latency of 3 cycles from a handshake at the request port to out_valid, when there is no backpressure.
REQ-021 SHALL sustain a throughput of 1 result per cycle while out_ready=1.
REQ-022 SHALL stall all stages under backpressure when out_valid=1 and out_ready=0; out_* SHALL hold stable and no data SHALL be lost or duplicated.
REQ-023 SHALL fill bubbles: an empty stage advances even while a downstream stage is stalled.
REQ-024 SHALL accept a new grant in the same cycle that out_valid/out_ready completes a handshake and the pipeline is full.

Reset
REQ-025 SHALL, when rst_n=0, clear all stage valid bits asynchronously; out_valid=0, out_msg=0, out_err=0, out_ovf=0, out_src=0.
REQ-026 SHALL hold req0_ready=req1_ready=0 while in reset.
REQ-027 SHALL reset the round-robin pointer to favour req0.
REQ-028 SHALL discard all in-flight codewords when reset is asserted mid-operation; the first result after reset comes from a post-reset grant.

Configuration
REQ-029 SHALL, with AN13_ERR_CNT_EN defined, add outputs err_cnt0/err_cnt1 (CNT_W each).
  - Each counter SHALL increment by one when a result handshake for that source has out_err=1.
  - Each counter SHALL saturate at all-ones.
  - Each counter SHALL reset to 0.
REQ-030 SHALL, without AN13_ERR_CNT_EN, have no counter ports or counter logic.

Structure
REQ-031 SHALL place A=13, BARRETT_M=19, BARRETT_K=8, message width 3 and residue width 4 in shared package an13_pkg.
REQ-032 SHALL implement the residue-to-offset table as combinational sub-module an13_corr_lut, with input residue[3:0] and output signed offset[2:0]; residue values 13-15 map to 0.

Verification
REQ-033 SHALL cover: req0_cw=65 -> after 3 cycles out_msg=5, out_err=0, out_ovf=0, out_src=0.
REQ-034 SHALL cover: req1_cw=73 (65+8) -> out_msg=5, out_err=1, out_src=1; req1_cw=68 -> out_msg=4.
REQ-035 SHALL cover: req0_cw=46 -> out_msg=6, out_err=1.
REQ-036 SHALL cover: both requesters continuously valid for 6 cycles -> out_src sequence 0,1,0,1,0,1.
REQ-037 SHALL cover backpressure:
  - stimulus: out_ready=0 for 4 cycles while 5 codewords are offered;
  - response: reqN_ready drops once the pipeline is full, out_* stay stable, and all 5 results emerge in order.
REQ-038 SHALL cover: rst_n pulsed low with 3 codewords in flight -> no stale out_valid afterwards; err_cnt0=0 when AN13_ERR_CNT_EN is defined.
